// File: rtl/branch_sched.sv
// rtl/branch_sched.sv - D-stage branch sequencer: operand wait, CMP drive, PC redirect, stats
// Holds F/D until forwarded operands are final, then evaluates and redirects.
module branch_sched #(
  parameter int         CNT_W    = 16,
  parameter logic [3:0] OP_AEQUB = 4'd10,
  parameter logic [3:0] OP_AGTZ  = 4'd11,
  parameter logic [3:0] OP_AGEZ  = 4'd12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_valid,
  input  logic [3:0]       br_op,
  input  logic [31:0]      br_pc,
  input  logic [15:0]      br_offset,
  input  logic [31:0]      fwd_a,
  input  logic [31:0]      fwd_b,
  input  logic             a_ready,
  input  logic             b_ready,
  input  logic             branch_true,
  output logic [31:0]      cmpa,
  output logic [31:0]      cmpb,
  output logic [3:0]       cmpop,
  output logic             stall,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_taken,
  output logic [CNT_W-1:0] stat_stall
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EVAL = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic        is_branch;
  logic        ops_ready;
  logic        capture;
  logic [31:0] target;
  logic [31:0] target_q;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  assign is_branch = (br_op == OP_AEQUB) || (br_op == OP_AGTZ) || (br_op == OP_AGEZ);
  // Sign-test ops only read rs, so rt readiness must not hold them up.
  assign ops_ready = (br_op == OP_AEQUB) ? (a_ready & b_ready) : a_ready;
  assign target    = br_pc + 32'd4 + {{14{br_offset[15]}}, br_offset, 2'b00};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (br_valid && is_branch) state_nxt = ops_ready ? EVAL : WAIT;
      WAIT: begin
        if (!br_valid)     state_nxt = IDLE;
        else if (ops_ready) state_nxt = EVAL;
      end
      EVAL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall    = 1'b0;
    redirect = 1'b0;
    capture  = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          stall   = br_valid && is_branch;
          capture = br_valid && is_branch && ops_ready;
        end
        WAIT: begin
          stall   = 1'b1;
          capture = br_valid && ops_ready;
        end
        EVAL:    redirect = branch_true;
        default: ;
      endcase
    end
  end

  assign redirect_pc = target_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cmpa          <= '0;
      cmpb          <= '0;
      cmpop         <= '0;
      target_q      <= '0;
      stat_branches <= '0;
      stat_taken    <= '0;
      stat_stall    <= '0;
    end else begin
      if (capture) begin
        cmpa     <= fwd_a;
        cmpb     <= fwd_b;
        cmpop    <= br_op;
        target_q <= target;
      end
      if (state == EVAL) begin
        cmpop <= '0;
        if (stat_branches != CNT_MAX) stat_branches <= stat_branches + 1'b1;
        if (branch_true && stat_taken != CNT_MAX) stat_taken <= stat_taken + 1'b1;
      end
      if (stall && stat_stall != CNT_MAX) stat_stall <= stat_stall + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_sched.sv
// tb/tb_branch_sched.sv - directed self-checking bench for branch_sched
// A 16-bit and a 4-bit counter build share the same stimulus.
module tb_branch_sched;

  localparam logic [3:0] AEQUB = 4'd10;
  localparam logic [3:0] AGTZ  = 4'd11;
  localparam logic [3:0] AGEZ  = 4'd12;

  logic        clk = 1'b0;
  logic        reset;
  logic        br_valid;
  logic [3:0]  br_op;
  logic [31:0] br_pc;
  logic [15:0] br_offset;
  logic [31:0] fwd_a, fwd_b;
  logic        a_ready, b_ready;
  logic        branch_true;

  logic [31:0] cmpa, cmpb, redirect_pc;
  logic [3:0]  cmpop;
  logic        stall, redirect;
  logic [15:0] stat_branches, stat_taken, stat_stall;

  logic [31:0] s_cmpa, s_cmpb, s_redirect_pc;
  logic [3:0]  s_cmpop;
  logic        s_stall, s_redirect;
  logic [3:0]  s_branches, s_taken, s_stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_sched #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .br_valid(br_valid), .br_op(br_op), .br_pc(br_pc),
    .br_offset(br_offset), .fwd_a(fwd_a), .fwd_b(fwd_b), .a_ready(a_ready),
    .b_ready(b_ready), .branch_true(branch_true), .cmpa(cmpa), .cmpb(cmpb),
    .cmpop(cmpop), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_taken(stat_taken), .stat_stall(stat_stall)
  );

  branch_sched #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .br_valid(br_valid), .br_op(br_op), .br_pc(br_pc),
    .br_offset(br_offset), .fwd_a(fwd_a), .fwd_b(fwd_b), .a_ready(a_ready),
    .b_ready(b_ready), .branch_true(branch_true), .cmpa(s_cmpa), .cmpb(s_cmpb),
    .cmpop(s_cmpop), .stall(s_stall), .redirect(s_redirect), .redirect_pc(s_redirect_pc),
    .stat_branches(s_branches), .stat_taken(s_taken), .stat_stall(s_stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One branch with no WAIT cycles: acceptance cycle, then EVAL.
  task automatic do_branch(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic brdy, input logic [31:0] pc,
                           input logic [15:0] off, input logic bt, input logic [31:0] exp_pc);
    br_valid = 1'b1; br_op = op; fwd_a = a; fwd_b = b;
    a_ready = 1'b1; b_ready = brdy; br_pc = pc; br_offset = off;
    #1;
    check({tag, "_accept_stall"}, {31'd0, stall}, 32'd1);
    tick();
    br_valid = 1'b0; a_ready = 1'b0; b_ready = 1'b0; branch_true = bt;
    #1;
    check({tag, "_eval_stall"}, {31'd0, stall}, 32'd0);
    check({tag, "_redirect"}, {31'd0, redirect}, {31'd0, bt});
    check({tag, "_cmpop"}, {28'd0, cmpop}, {28'd0, op});
    if (bt) check({tag, "_redirect_pc"}, redirect_pc, exp_pc);
    tick();
    branch_true = 1'b0;
  endtask

  initial begin
    reset = 1'b1; br_valid = 1'b0; br_op = 4'd0; br_pc = '0; br_offset = '0;
    fwd_a = '0; fwd_b = '0; a_ready = 1'b0; b_ready = 1'b0; branch_true = 1'b0;
    tick(); tick();
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_redirect", {31'd0, redirect}, 32'd0);
    check("rst_cmpop", {28'd0, cmpop}, 32'd0);
    check("rst_cmpa", cmpa, 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_branches", {16'd0, stat_branches}, 32'd0);
    reset = 1'b0;
    tick();

    // Non-branch opcode never stalls.
    br_valid = 1'b1; br_op = 4'd3; a_ready = 1'b1; b_ready = 1'b1;
    #1;
    check("nonbranch_stall", {31'd0, stall}, 32'd0);
    tick();
    br_valid = 1'b0;

    do_branch("aequb_taken", AEQUB, 32'h0000_1234, 32'h0000_1234, 1'b1,
              32'h0000_3000, 16'h0004, 1'b1, 32'h0000_3014);
    check("t1_cmpa", cmpa, 32'h0000_1234);
    check("t1_cmpop_clr", {28'd0, cmpop}, 32'd0);
    check("t1_branches", {16'd0, stat_branches}, 32'd1);
    check("t1_taken", {16'd0, stat_taken}, 32'd1);
    check("t1_stall", {16'd0, stat_stall}, 32'd1);

    do_branch("agtz_nt", AGTZ, 32'hFFFF_FFFF, 32'h0, 1'b1,
              32'h0000_3000, 16'h0004, 1'b0, 32'h0000_3014);
    check("t2_branches", {16'd0, stat_branches}, 32'd2);
    check("t2_taken", {16'd0, stat_taken}, 32'd1);

    do_branch("agez_nob", AGEZ, 32'h0, 32'hDEAD_BEEF, 1'b0,
              32'h0000_4000, 16'h0010, 1'b1, 32'h0000_4044);
    check("t3_branches", {16'd0, stat_branches}, 32'd3);
    check("t3_taken", {16'd0, stat_taken}, 32'd2);
    check("t3_stall", {16'd0, stat_stall}, 32'd3);

    do_branch("neg_off", AEQUB, 32'h7, 32'h7, 1'b1,
              32'h0000_3010, 16'hFFFC, 1'b1, 32'h0000_3004);
    check("t4_stall", {16'd0, stat_stall}, 32'd4);

    // Operand wait: b_ready low for cycles 0-2, high in cycle 3.
    br_valid = 1'b1; br_op = AEQUB; fwd_a = 32'h5; fwd_b = 32'h5;
    a_ready = 1'b1; b_ready = 1'b0; br_pc = 32'h0000_5000; br_offset = 16'h0001;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) b_ready = 1'b1;
      #1;
      check($sformatf("wait_stall_c%0d", c), {31'd0, stall}, 32'd1);
      check($sformatf("wait_redirect_c%0d", c), {31'd0, redirect}, 32'd0);
      tick();
    end
    br_valid = 1'b0; a_ready = 1'b0; b_ready = 1'b0; branch_true = 1'b1;
    #1;
    check("wait_eval_redirect", {31'd0, redirect}, 32'd1);
    check("wait_eval_pc", redirect_pc, 32'h0000_5008);
    check("wait_cmpb", cmpb, 32'h5);
    tick();
    branch_true = 1'b0;
    check("wait_branches", {16'd0, stat_branches}, 32'd5);
    check("wait_taken", {16'd0, stat_taken}, 32'd4);
    check("wait_stall_cnt", {16'd0, stat_stall}, 32'd8);

    // Abort out of WAIT: two WAIT cycles, the second with br_valid dropped.
    br_valid = 1'b1; br_op = AEQUB; a_ready = 1'b1; b_ready = 1'b0;
    tick();
    #1;
    check("abort_wait1", {31'd0, stall}, 32'd1);
    tick();
    br_valid = 1'b0; branch_true = 1'b1;
    #1;
    check("abort_wait2", {31'd0, stall}, 32'd1);
    check("abort_wait2_redir", {31'd0, redirect}, 32'd0);
    tick();
    #1;
    check("abort_idle_stall", {31'd0, stall}, 32'd0);
    check("abort_idle_redir", {31'd0, redirect}, 32'd0);
    check("abort_branches", {16'd0, stat_branches}, 32'd5);
    check("abort_stall_cnt", {16'd0, stat_stall}, 32'd11);
    branch_true = 1'b0;
    a_ready = 1'b0;

    // Reset during EVAL with a taken result.
    br_valid = 1'b1; br_op = AEQUB; a_ready = 1'b1; b_ready = 1'b1;
    tick();
    br_valid = 1'b0; branch_true = 1'b1; reset = 1'b1;
    #1;
    check("rst_eval_redirect", {31'd0, redirect}, 32'd0);
    tick();
    reset = 1'b0; branch_true = 1'b0;
    #1;
    check("rst_eval_cmpop", {28'd0, cmpop}, 32'd0);
    check("rst_eval_branches", {16'd0, stat_branches}, 32'd0);
    check("rst_eval_taken", {16'd0, stat_taken}, 32'd0);
    check("rst_eval_stall", {16'd0, stat_stall}, 32'd0);

    // Saturation: 16 taken branches into both builds.
    for (int i = 0; i < 16; i++)
      do_branch("sat", AGEZ, 32'h1, 32'h0, 1'b1, 32'h0000_6000, 16'h0000, 1'b1, 32'h0000_6004);
    check("sat_small_taken", {28'd0, s_taken}, 32'h0000_000F);
    check("sat_small_branches", {28'd0, s_branches}, 32'h0000_000F);
    check("sat_small_stall", {28'd0, s_stall_cnt}, 32'h0000_000F);
    check("sat_wide_taken", {16'd0, stat_taken}, 32'd16);
    do_branch("sat_more", AGEZ, 32'h1, 32'h0, 1'b1, 32'h0000_6000, 16'h0000, 1'b1, 32'h0000_6004);
    check("sat_small_hold", {28'd0, s_taken}, 32'h0000_000F);
    check("sat_wide_17", {16'd0, stat_taken}, 32'd17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
